// File: rtl/stream_fetcher_pkg.sv
// Shared types and defaults for the stream fetcher.
// Optional macro STREAM_FETCHER_CHECK_EN (see stream_fetcher.sv) adds the err output.
package stream_fetcher_pkg;

    localparam int unsigned SF_ADDR_WIDTH  = 48;
    localparam int unsigned SF_DATA_WIDTH  = 64;
    localparam int unsigned SF_TAG_COUNT   = 4;
    localparam int unsigned SF_COUNT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } sf_state_t;

    // Ceiling log2, valid for the power-of-two tag counts used here (2..64).
    function automatic int unsigned sf_log2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 1; i < value; i = i << 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/stream_reorder_buf.sv
// Reorder buffer: one slot per tag, valid bit per slot, in-order head pointer.
// A write to the head slot is forwarded straight to the head outputs so a
// response can be emitted the cycle after it arrives.
module stream_reorder_buf #(
    parameter int unsigned TAG_COUNT  = 4,
    parameter int unsigned TAG_WIDTH  = 2,
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [TAG_WIDTH-1:0]  wr_tag,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  pop,
    output logic                  head_ready,
    output logic [DATA_WIDTH-1:0] head_data
);

    logic [DATA_WIDTH-1:0] mem [TAG_COUNT];
    logic [TAG_COUNT-1:0]  valid;
    logic [TAG_WIDTH-1:0]  head;
    logic                  wr_head;

    // Slot storage; contents are qualified by valid so no reset is needed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_tag] <= wr_data;
        end
    end

    // Valid bits and head pointer; a pop clears after a same-cycle write so a
    // forwarded head word is never left marked valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            head  <= '0;
        end else begin
            if (wr_en) begin
                valid[wr_tag] <= 1'b1;
            end
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + TAG_WIDTH'(1);
            end
        end
    end

    // Head word selection with write-through forwarding.
    always_comb begin
        wr_head    = wr_en && (wr_tag == head);
        head_ready = valid[head] || wr_head;
        head_data  = valid[head] ? mem[head] : wr_data;
    end

endmodule

// File: rtl/stream_fetcher.sv
// Stream fetcher: issues tagged sequential word reads, reorders responses and
// emits them in address order.
// Optional macro STREAM_FETCHER_CHECK_EN adds a sticky err output flagging
// pushes to tags that are not outstanding (or arriving while idle).
module stream_fetcher
    import stream_fetcher_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = SF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH  = SF_DATA_WIDTH,
    parameter int unsigned TAG_COUNT   = SF_TAG_COUNT,
    parameter int unsigned COUNT_WIDTH = SF_COUNT_WIDTH,
    localparam int unsigned TAG_WIDTH  = sf_log2(TAG_COUNT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  start_addr,
    input  logic [COUNT_WIDTH-1:0] start_count,
    output logic                   req,
    input  logic                   req_stall,
    output logic [TAG_WIDTH-1:0]   req_tag,
    output logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic                   push,
    input  logic [TAG_WIDTH-1:0]   push_tag,
    input  logic [DATA_WIDTH-1:0]  data,
    output logic                   out_push,
    output logic [DATA_WIDTH-1:0]  out_data,
    input  logic                   out_stall,
    output logic                   busy,
    output logic                   done
`ifdef STREAM_FETCHER_CHECK_EN
    ,
    output logic                   err
`endif
);

    localparam logic [TAG_WIDTH:0] TAG_FULL = (TAG_WIDTH + 1)'(TAG_COUNT);

    sf_state_t              state;
    sf_state_t              state_next;
    logic [COUNT_WIDTH-1:0] req_left;
    logic [COUNT_WIDTH-1:0] out_left;
    logic [TAG_WIDTH:0]     occ;
    logic [TAG_COUNT-1:0]   pend;
    logic                   start_go;
    logic                   start_zero;
    logic                   push_ok;
    logic                   pop;
    logic                   head_ready;
    logic [DATA_WIDTH-1:0]  head_data;

    // Control qualifiers shared by the FSM and the datapath.
    always_comb begin
        start_go   = start && (state == IDLE) && (start_count != '0);
        start_zero = start && (state == IDLE) && (start_count == '0);
        push_ok    = push && (state != IDLE) && pend[push_tag];
        pop        = head_ready && !out_stall;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start_go) state_next = RUN;
            RUN:     if (req && (req_left == COUNT_WIDTH'(1))) state_next = DRAIN;
            DRAIN:   if (out_left == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs; req counts both in-flight and buffered slots as used credit.
    always_comb begin
        req  = (state == RUN) && !req_stall && (occ < TAG_FULL);
        busy = (state != IDLE);
    end

    // Request/response bookkeeping and the registered output word.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_tag  <= '0;
            req_addr <= '0;
            req_left <= '0;
            out_left <= '0;
            occ      <= '0;
            pend     <= '0;
            out_push <= 1'b0;
            out_data <= '0;
            done     <= 1'b0;
        end else begin
            out_push <= pop;
            if (pop) begin
                out_data <= head_data;
            end
            // out_left reaches zero on the edge that registers the last word,
            // so DRAIN with out_left==0 is exactly the cycle of the last out_push.
            done <= start_zero || ((state == DRAIN) && (out_left == '0));

            if (start_go) begin
                req_addr <= start_addr;
                req_left <= start_count;
                out_left <= start_count;
            end else begin
                if (req) begin
                    req_addr <= req_addr + ADDR_WIDTH'(1);
                    req_left <= req_left - COUNT_WIDTH'(1);
                end
                if (pop) begin
                    out_left <= out_left - COUNT_WIDTH'(1);
                end
            end

            if (req) begin
                req_tag       <= req_tag + TAG_WIDTH'(1);
                pend[req_tag] <= 1'b1;
            end
            if (push_ok) begin
                pend[push_tag] <= 1'b0;
            end

            unique case ({req, pop})
                2'b10:   occ <= occ + (TAG_WIDTH + 1)'(1);
                2'b01:   occ <= occ - (TAG_WIDTH + 1)'(1);
                default: occ <= occ;
            endcase
        end
    end

`ifdef STREAM_FETCHER_CHECK_EN
    // Sticky protocol error: push to a tag that is not outstanding.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (push && ((state == IDLE) || !pend[push_tag])) begin
            err <= 1'b1;
        end
    end
`endif

    stream_reorder_buf #(
        .TAG_COUNT  (TAG_COUNT),
        .TAG_WIDTH  (TAG_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rob (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (push_ok),
        .wr_tag     (push_tag),
        .wr_data    (data),
        .pop        (pop),
        .head_ready (head_ready),
        .head_data  (head_data)
    );

endmodule
